// File: rtl/bp_pkg.sv
// Shared encodings and the per-instruction prediction metadata
// carried alongside the pipeline from IF to EX.
package bp_pkg;

    typedef enum logic [1:0] {
        BT_OTHER = 2'b00,
        BT_JAL   = 2'b01,
        BT_BR    = 2'b10,
        BT_JALR  = 2'b11
    } btype_e;

    typedef struct packed {
        logic        valid;
        logic [15:0] pc;
        logic        ptaken;
        logic [15:0] ptarget;
    } meta_t;

    localparam logic [15:0] PC_STEP = 16'd4;

endpackage

// File: rtl/bp_meta_stage.sv
// One pipeline register for prediction metadata. A kill on a load
// cycle replaces the incoming entry with an empty (invalid) one.
module bp_meta_stage
    import bp_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  kill,
    input  meta_t d,
    output meta_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= kill ? '0 : d;
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Resolves control transfers in EX against the prediction made in IF,
// producing the flush/redirect, predictor training and perf counters.
module branch_resolver
    import bp_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 IF_DONE,
    input  logic                 MEM_DONE,
    input  logic [15:0]          IF_PC,
    input  logic                 IF_pTaken,
    input  logic [15:0]          IF_pTarget,
    input  logic [1:0]           EX_bType,
    input  logic                 EX_rTaken,
    input  logic [15:0]          EX_bTarget,
    output logic                 flush,
    output logic [15:0]          redirect_PC,
    output logic [1:0]           bp_bType,
    output logic                 bp_rTaken,
    output logic [15:0]          bp_PC,
    output logic [15:0]          bp_bTarget,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] mispred_cnt
);

    // Handshake: every output here is a level that the rest of the pipeline
    // samples only on a cycle where adv = IF_DONE && MEM_DONE; while adv is
    // low all state holds, so flush and bp_* stay stable across the stall.
    logic   adv;
    meta_t  if_meta;
    meta_t  id_meta;
    meta_t  ex_meta;
    btype_e ex_type;
    logic   a_taken;
    logic   is_ctrl;

    assign adv     = IF_DONE && MEM_DONE;
    assign ex_type = btype_e'(EX_bType);

    always_comb begin
        if_meta         = '0;
        if_meta.valid   = 1'b1;
        if_meta.pc      = IF_PC;
        if_meta.ptaken  = IF_pTaken;
        if_meta.ptarget = IF_pTarget;
    end

    bp_meta_stage u_id_stage (
        .clk  (clk),
        .rst  (rst),
        .load (adv),
        .kill (flush),
        .d    (if_meta),
        .q    (id_meta)
    );

    bp_meta_stage u_ex_stage (
        .clk  (clk),
        .rst  (rst),
        .load (adv),
        .kill (flush),
        .d    (id_meta),
        .q    (ex_meta)
    );

    // Taken-ness is gated by EX valid so an empty slot redirects to PC+4.
    always_comb begin
        a_taken = 1'b0;
        is_ctrl = 1'b0;
        case (ex_type)
            BT_JAL, BT_JALR: begin
                a_taken = 1'b1;
                is_ctrl = 1'b1;
            end
            BT_BR: begin
                a_taken = EX_rTaken;
                is_ctrl = 1'b1;
            end
            default: begin
                a_taken = 1'b0;
                is_ctrl = 1'b0;
            end
        endcase
        a_taken = a_taken && ex_meta.valid;
        is_ctrl = is_ctrl && ex_meta.valid;
    end

    always_comb begin
        flush = 1'b0;
        if (ex_meta.valid) begin
            flush = (ex_meta.ptaken != a_taken) ||
                    (a_taken && (ex_meta.ptarget != EX_bTarget));
        end
    end

    assign redirect_PC = a_taken ? EX_bTarget : (ex_meta.pc + PC_STEP);

    // JALR targets are register-dependent, so they never train the predictor.
    always_comb begin
        bp_bType = BT_OTHER;
        if (ex_meta.valid && (ex_type == BT_JAL || ex_type == BT_BR)) begin
            bp_bType = EX_bType;
        end
    end

    assign bp_rTaken  = a_taken;
    assign bp_PC      = ex_meta.pc;
    assign bp_bTarget = EX_bTarget;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (adv) begin
            if (is_ctrl && (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + CNT_WIDTH'(1);
            end
            if (flush && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed scenario bench for branch_resolver (4-bit counters so that
// saturation is reachable in a short run).
module tb_branch_resolver;

    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          if_done;
    logic          mem_done;
    logic [15:0]   if_pc;
    logic          if_ptaken;
    logic [15:0]   if_ptarget;
    logic [1:0]    ex_btype;
    logic          ex_rtaken;
    logic [15:0]   ex_btarget;
    logic          flush;
    logic [15:0]   redirect_pc;
    logic [1:0]    bp_btype;
    logic          bp_rtaken;
    logic [15:0]   bp_pc;
    logic [15:0]   bp_btarget;
    logic [CW-1:0] branch_cnt;
    logic [CW-1:0] mispred_cnt;

    int            checks;
    int            passed;
    logic [CW-1:0] exp_branch;
    logic [CW-1:0] exp_mispred;

    branch_resolver #(.CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .IF_DONE     (if_done),
        .MEM_DONE    (mem_done),
        .IF_PC       (if_pc),
        .IF_pTaken   (if_ptaken),
        .IF_pTarget  (if_ptarget),
        .EX_bType    (ex_btype),
        .EX_rTaken   (ex_rtaken),
        .EX_bTarget  (ex_btarget),
        .flush       (flush),
        .redirect_PC (redirect_pc),
        .bp_bType    (bp_btype),
        .bp_rTaken   (bp_rtaken),
        .bp_PC       (bp_pc),
        .bp_bTarget  (bp_btarget),
        .branch_cnt  (branch_cnt),
        .mispred_cnt (mispred_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_adv(input logic a);
        if_done  = 1'b1;
        mem_done = a;
    endtask

    task automatic set_ex(input logic [1:0] t, input logic rt, input logic [15:0] tgt);
        ex_btype   = t;
        ex_rtaken  = rt;
        ex_btarget = tgt;
        #1;
    endtask

    // Push one instruction into EX, followed by a non-predicted filler in ID.
    task automatic load_ex(input logic [15:0] pc, input logic pt, input logic [15:0] ptgt);
        set_adv(1'b1);
        set_ex(2'b00, 1'b0, 16'h0000);
        if_pc = pc; if_ptaken = pt; if_ptarget = ptgt;
        step();
        if_pc = 16'h0F00; if_ptaken = 1'b0; if_ptarget = 16'h0000;
        step();
        set_adv(1'b0);
    endtask

    // ---------------- test tasks ----------------
    task automatic test_reset();
        rst = 1'b1;
        set_adv(1'b1);
        set_ex(2'b00, 1'b0, 16'h0000);
        step();
        checks++;
        if (flush !== 1'b0 || bp_btype !== 2'b00 || redirect_pc !== 16'h0004)
            $display("FAIL reset_outputs: flush=%b bp_bType=%b redirect=%h, required 0/00/0004", flush, bp_btype, redirect_pc);
        else passed++;
        checks++;
        if (branch_cnt !== 4'h0 || mispred_cnt !== 4'h0)
            $display("FAIL reset_counters: branch=%h mispred=%h, required 0/0", branch_cnt, mispred_cnt);
        else passed++;
        rst = 1'b0;
        exp_branch = 0; exp_mispred = 0;
        set_adv(1'b0);
        step();
        checks++;
        if (flush !== 1'b0 || redirect_pc !== 16'h0004)
            $display("FAIL post_reset_idle: flush=%b redirect=%h, required 0/0004", flush, redirect_pc);
        else passed++;
    endtask

    task automatic test_mispredict_taken();
        load_ex(16'h0040, 1'b0, 16'h0000);
        set_ex(2'b10, 1'b1, 16'h0080);
        checks++;
        if (flush !== 1'b1 || redirect_pc !== 16'h0080 || bp_btype !== 2'b10 || bp_pc !== 16'h0040 || bp_rtaken !== 1'b1)
            $display("FAIL br_mispred_out: flush=%b redirect=%h bp_bType=%b bp_PC=%h bp_rTaken=%b, required 1/0080/10/0040/1",
                     flush, redirect_pc, bp_btype, bp_pc, bp_rtaken);
        else passed++;
        set_adv(1'b1);
        step();
        exp_branch++; exp_mispred++;
        checks++;
        if (branch_cnt !== exp_branch || mispred_cnt !== exp_mispred)
            $display("FAIL br_mispred_cnt: branch=%h mispred=%h, required %h/%h", branch_cnt, mispred_cnt, exp_branch, exp_mispred);
        else passed++;
        checks++;
        if (flush !== 1'b0 || bp_btype !== 2'b00)
            $display("FAIL br_mispred_killed: flush=%b bp_bType=%b, required 0/00", flush, bp_btype);
        else passed++;
    endtask

    task automatic test_correct_predict();
        load_ex(16'h0040, 1'b1, 16'h0080);
        set_ex(2'b10, 1'b1, 16'h0080);
        checks++;
        if (flush !== 1'b0 || bp_btype !== 2'b10 || bp_btarget !== 16'h0080)
            $display("FAIL br_correct_out: flush=%b bp_bType=%b bp_bTarget=%h, required 0/10/0080", flush, bp_btype, bp_btarget);
        else passed++;
        set_adv(1'b1);
        step();
        exp_branch++;
        checks++;
        if (branch_cnt !== exp_branch || mispred_cnt !== exp_mispred)
            $display("FAIL br_correct_cnt: branch=%h mispred=%h, required %h/%h", branch_cnt, mispred_cnt, exp_branch, exp_mispred);
        else passed++;
    endtask

    task automatic test_stall_hold();
        int held;
        held = 0;
        load_ex(16'h0060, 1'b0, 16'h0000);
        set_ex(2'b10, 1'b1, 16'h0090);
        for (int i = 0; i < 5; i++) begin
            if (flush === 1'b1 && redirect_pc === 16'h0090 && bp_btype === 2'b10) held++;
            step();
        end
        if (flush === 1'b1) held++;
        checks++;
        if (held !== 6)
            $display("FAIL stall_flush_held: held=%0d cycles, required 6", held);
        else passed++;
        checks++;
        if (branch_cnt !== exp_branch || mispred_cnt !== exp_mispred)
            $display("FAIL stall_no_count: branch=%h mispred=%h, required %h/%h", branch_cnt, mispred_cnt, exp_branch, exp_mispred);
        else passed++;
        set_adv(1'b1);
        step();
        exp_branch++; exp_mispred++;
        checks++;
        if (branch_cnt !== exp_branch || mispred_cnt !== exp_mispred || flush !== 1'b0)
            $display("FAIL stall_release: branch=%h mispred=%h flush=%b, required %h/%h/0",
                     branch_cnt, mispred_cnt, flush, exp_branch, exp_mispred);
        else passed++;
    endtask

    task automatic test_jalr();
        load_ex(16'h0100, 1'b0, 16'h0000);
        set_ex(2'b11, 1'b0, 16'h0200);
        checks++;
        if (flush !== 1'b1 || redirect_pc !== 16'h0200 || bp_btype !== 2'b00)
            $display("FAIL jalr_out: flush=%b redirect=%h bp_bType=%b, required 1/0200/00", flush, redirect_pc, bp_btype);
        else passed++;
        set_adv(1'b1);
        step();
        exp_branch++; exp_mispred++;
        checks++;
        if (branch_cnt !== exp_branch || mispred_cnt !== exp_mispred)
            $display("FAIL jalr_cnt: branch=%h mispred=%h, required %h/%h", branch_cnt, mispred_cnt, exp_branch, exp_mispred);
        else passed++;
    endtask

    task automatic test_wrong_target();
        load_ex(16'h0120, 1'b1, 16'h0100);
        set_ex(2'b01, 1'b0, 16'h0200);
        checks++;
        if (flush !== 1'b1 || redirect_pc !== 16'h0200 || bp_btype !== 2'b01)
            $display("FAIL jal_wrong_target: flush=%b redirect=%h bp_bType=%b, required 1/0200/01", flush, redirect_pc, bp_btype);
        else passed++;
        set_adv(1'b1);
        step();
        exp_branch++; exp_mispred++;
    endtask

    task automatic test_pc_wrap();
        load_ex(16'hFFFC, 1'b1, 16'h1234);
        set_ex(2'b10, 1'b0, 16'h1234);
        checks++;
        if (flush !== 1'b1 || redirect_pc !== 16'h0000 || bp_rtaken !== 1'b0)
            $display("FAIL pc_wrap: flush=%b redirect=%h bp_rTaken=%b, required 1/0000/0", flush, redirect_pc, bp_rtaken);
        else passed++;
        set_adv(1'b1);
        step();
        exp_branch++; exp_mispred++;
        checks++;
        if (branch_cnt !== exp_branch || mispred_cnt !== exp_mispred)
            $display("FAIL pc_wrap_cnt: branch=%h mispred=%h, required %h/%h", branch_cnt, mispred_cnt, exp_branch, exp_mispred);
        else passed++;
    endtask

    task automatic test_async_reset();
        load_ex(16'h0300, 1'b0, 16'h0000);
        set_ex(2'b01, 1'b0, 16'h0400);
        checks++;
        if (flush !== 1'b1)
            $display("FAIL async_pre: flush=%b, required 1", flush);
        else passed++;
        #2;
        rst = 1'b1;
        #1;
        exp_branch = 0; exp_mispred = 0;
        checks++;
        if (flush !== 1'b0 || branch_cnt !== exp_branch || mispred_cnt !== exp_mispred || bp_btype !== 2'b00)
            $display("FAIL async_reset: flush=%b branch=%h mispred=%h bp_bType=%b, required 0/0/0/00",
                     flush, branch_cnt, mispred_cnt, bp_btype);
        else passed++;
        step();
        rst = 1'b0;
        set_ex(2'b00, 1'b0, 16'h0000);
    endtask

    task automatic test_back_to_back();
        set_adv(1'b1);
        if_ptaken = 1'b0; if_ptarget = 16'h0000;
        set_ex(2'b00, 1'b0, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            if_pc = 16'h0500 + 16'(i * 4);
            step();
        end
        set_ex(2'b10, 1'b0, 16'h0600);
        for (int i = 0; i < 20; i++) begin
            if_pc = 16'h0508 + 16'(i * 4);
            step();
            if (exp_branch != 4'hF) exp_branch++;
            if (i == 9) begin
                checks++;
                if (branch_cnt !== exp_branch || flush !== 1'b0)
                    $display("FAIL b2b_count10: branch=%h flush=%b, required %h/0", branch_cnt, flush, exp_branch);
                else passed++;
            end
        end
        checks++;
        if (branch_cnt !== 4'hF || exp_branch !== 4'hF || mispred_cnt !== exp_mispred)
            $display("FAIL b2b_saturate: branch=%h mispred=%h, required F/%h", branch_cnt, mispred_cnt, exp_mispred);
        else passed++;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        checks = 0; passed = 0;
        exp_branch = 0; exp_mispred = 0;
        rst = 1'b1;
        if_pc = 16'h0000; if_ptaken = 1'b0; if_ptarget = 16'h0000;
        ex_btype = 2'b00; ex_rtaken = 1'b0; ex_btarget = 16'h0000;
        if_done = 1'b0; mem_done = 1'b0;
        test_reset();
        test_mispredict_taken();
        test_correct_predict();
        test_stall_hold();
        test_jalr();
        test_wrong_target();
        test_pc_wrap();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32, the width of each saturating performance counter.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port IF_DONE  input  1  fetch-side ready; pipeline advances only when IF_DONE && MEM_DONE ("adv").
REQ-005 SHALL have port MEM_DONE  input  1  memory-side ready.
REQ-006 SHALL have port IF_PC  input  16  PC of the instruction in IF.
REQ-007 SHALL have port IF_pTaken  input  1  predictor taken decision for IF_PC.
REQ-008 SHALL have port IF_pTarget  input  16  predictor target for IF_PC.
REQ-009 SHALL have port EX_bType  input  2  decoded type in EX: 00 other, 01 JAL, 10 Btype, 11 JALR.
REQ-010 SHALL have port EX_rTaken  input  1  branch compare result in EX (meaningful for Btype only).
REQ-011 SHALL have port EX_bTarget  input  16  computed target in EX.
REQ-012 SHALL have port flush  output  1  wrong-path kill for IF and ID.
REQ-013 SHALL have port redirect_PC  output  16  correct next PC when flush=1.
REQ-014 SHALL have port bp_bType  output  2  update type to predictor (00/01/10 only).
REQ-015 SHALL have port bp_rTaken, bp_PC[15:0], bp_bTarget[15:0]  output  update payload to predictor.
REQ-016 SHALL have ports branch_cnt, mispred_cnt  output  CNT_WIDTH  resolved control-transfers and mispredictions.

Function
REQ-017 SHALL carry metadata {valid, PC, pTaken, pTarget} through two registered stages IF->ID and ID->EX, loaded on adv only, held otherwise.
REQ-018 On adv without flush, ID stage SHALL capture IF_PC/IF_pTaken/IF_pTarget with valid=1; EX stage SHALL capture ID stage.
REQ-019 On adv with flush, both stages SHALL load valid=0 (instructions in IF and ID are wrong-path).
REQ-020 Actual taken (aT) SHALL be 1 for JAL/JALR, EX_rTaken for Btype, 0 for 00.
REQ-021 flush SHALL be combinational: EX valid && (pTaken != aT || (aT && pTarget != EX_bTarget)); 0 when EX invalid.
REQ-022 redirect_PC SHALL be EX_bTarget if aT, else EX PC + 4 (16-bit modulo, 0xFFFC+4 wraps to 0x0000).
REQ-023 bp_bType SHALL equal EX_bType for 01/10 with EX valid, else 00 (JALR never trains predictor); bp_PC = EX PC, bp_rTaken = aT, bp_bTarget = EX_bTarget.
REQ-024 flush and bp_* SHALL remain stable while adv=0; consumer acts only on adv.
REQ-025 branch_cnt SHALL increment on adv when EX valid && EX_bType != 00; mispred_cnt on adv when flush=1; each counts once per instruction regardless of stall length.
REQ-026 Counters SHALL saturate at all-ones, never wrap.
REQ-027 Correct-path mispredict with pTaken=1, aT=1, wrong target SHALL flush and redirect to EX_bTarget.

Reset
REQ-028 On rst, both stage valid bits, branch_cnt and mispred_cnt SHALL clear to 0 immediately; PC/target fields to 0.
REQ-029 During and after reset until first adv, outputs SHALL be flush=0, bp_bType=00, redirect_PC=0x0004; rst mid-stall discards pending flush.

Structure
REQ-030 Package bp_pkg SHALL hold bType encodings (BT_OTHER, BT_JAL, BT_BR, BT_JALR) and the metadata struct typedef.
REQ-031 One sub-module bp_meta_stage SHALL implement a single metadata pipeline register with load, kill, async reset; instantiated twice.

Verification
REQ-032 Btype at 0x0040, pTaken=0, rTaken=1, target 0x0080 -> flush=1, redirect_PC=0x0080, bp_bType=10, mispred_cnt 0->1.
REQ-033 Btype at 0x0040, pTaken=1, pTarget=0x0080, rTaken=1, target 0x0080 -> flush=0, branch_cnt+1, mispred_cnt unchanged.
REQ-034 Mispredict with adv=0 for 5 cycles then adv -> flush held 6 cycles, mispred_cnt +1 only; next EX stage valid=0.
REQ-035 JALR at 0x0100, pTaken=0, target 0x0200 -> flush=1, redirect_PC=0x0200, bp_bType=00.
REQ-036 Btype at 0xFFFC, pTaken=1, rTaken=0 -> redirect_PC=0x0000; CNT_WIDTH=4 after 20 branches -> branch_cnt=0xF.
REQ-037 rst asserted asynchronously mid-stall with flush=1 -> flush=0, counters 0 before next clk edge.
